// File: rtl/datapath_controller_if.sv
// Handshake and control bundle between the datapath controller and its surroundings.
// Signal suffixes are from the controller's point of view.
interface datapath_controller_if;
  logic        s_i;
  logic        load_i;
  logic [15:0] in_i;
  logic        w_o;
  logic [2:0]  readnum_o;
  logic [2:0]  writenum_o;
  logic        write_o;
  logic        loada_o;
  logic        loadb_o;
  logic        loadc_o;
  logic        loads_o;
  logic        asel_o;
  logic        bsel_o;
  logic        vsel_o;
  logic [1:0]  shift_o;
  logic [1:0]  aluop_o;
  logic [15:0] datapath_in_o;

  modport master (
    output s_i, load_i, in_i,
    input  w_o, readnum_o, writenum_o, write_o, loada_o, loadb_o, loadc_o, loads_o,
    input  asel_o, bsel_o, vsel_o, shift_o, aluop_o, datapath_in_o
  );

  modport slave (
    input  s_i, load_i, in_i,
    output w_o, readnum_o, writenum_o, write_o, loada_o, loadb_o, loadc_o, loads_o,
    output asel_o, bsel_o, vsel_o, shift_o, aluop_o, datapath_in_o
  );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer for the register-file/shifter/ALU datapath.
// Holds the instruction register and drives registered Moore control outputs.
module datapath_controller (
  input  logic                 clk,
  input  logic                 reset,
  datapath_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_t;

  state_t      state_q;
  logic [15:0] ir_q, ir_d;
  logic        w_q, write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q, vsel_q;
  logic [2:0]  readnum_q, writenum_q;
  logic [1:0]  shift_q, aluop_q;

  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic        is_mov_imm, is_mov_reg, is_mvn, is_alu, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu     = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  always_comb begin
    ir_d = ir_q;
    if ((state_q == S_WAIT) && bus.load_i) ir_d = bus.in_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ir_q <= '0;
    else       ir_q <= ir_d;
  end

  // Outputs are loaded together with the state they belong to, so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT;
      w_q        <= 1'b1;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      shift_q    <= '0;
      aluop_q    <= '0;
    end else begin
      w_q        <= 1'b0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      shift_q    <= '0;
      aluop_q    <= '0;
      case (state_q)
        S_WAIT: begin
          if (bus.s_i) state_q <= S_DECODE;
          else         w_q     <= 1'b1;
        end
        S_DECODE: begin
          if (is_mov_imm) begin
            state_q    <= S_WRITE_IMM;
            writenum_q <= rn;
            vsel_q     <= 1'b1;
            write_q    <= 1'b1;
          end else if (is_mov_reg || is_mvn) begin
            state_q   <= S_GET_B;
            readnum_q <= rm;
            loadb_q   <= 1'b1;
          end else if (is_alu) begin
            state_q   <= S_GET_A;
            readnum_q <= rn;
            loada_q   <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            w_q     <= 1'b1;
          end
        end
        S_GET_A: begin
          state_q   <= S_GET_B;
          readnum_q <= rm;
          loadb_q   <= 1'b1;
        end
        S_GET_B: begin
          state_q <= S_EXEC;
          shift_q <= sh;
          asel_q  <= is_mov_reg || is_mvn;
          aluop_q <= is_mov_reg ? 2'b00 : op;
          loads_q <= is_cmp;
          loadc_q <= !is_cmp;
        end
        S_EXEC: begin
          if (is_cmp) begin
            state_q <= S_WAIT;
            w_q     <= 1'b1;
          end else begin
            state_q    <= S_WRITE_REG;
            writenum_q <= rd;
            write_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_WAIT;
          w_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w_o           = w_q;
  assign bus.readnum_o     = readnum_q;
  assign bus.writenum_o    = writenum_q;
  assign bus.write_o       = write_q;
  assign bus.loada_o       = loada_q;
  assign bus.loadb_o       = loadb_q;
  assign bus.loadc_o       = loadc_q;
  assign bus.loads_o       = loads_q;
  assign bus.asel_o        = asel_q;
  // No instruction in this set takes the B operand from the immediate.
  assign bus.bsel_o        = 1'b0;
  assign bus.vsel_o        = vsel_q;
  assign bus.shift_o       = shift_q;
  assign bus.aluop_o       = aluop_q;
  assign bus.datapath_in_o = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: directed instructions plus random
// instruction words, compared against a per-instruction cycle-trace model.
`timescale 1ns/1ps
module tb_datapath_controller;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  localparam logic [15:0] D_IR  [6] = '{16'hD107, 16'hD1F0, 16'hA0A8, 16'hA900, 16'hB8E2, 16'hE000};
  localparam int          D_LAT [6] = '{2, 2, 5, 4, 4, 1};
  localparam logic [15:0] D_DP  [6] = '{16'h0007, 16'hFFF0, 16'hFFA8, 16'h0000, 16'hFFE2, 16'h0000};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  datapath_controller_if bus();
  datapath_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t pack_ctl();
    ctl_t c;
    c.w = bus.w_o;           c.readnum = bus.readnum_o; c.writenum = bus.writenum_o;
    c.write = bus.write_o;   c.loada = bus.loada_o;     c.loadb = bus.loadb_o;
    c.loadc = bus.loadc_o;   c.loads = bus.loads_o;     c.asel = bus.asel_o;
    c.bsel = bus.bsel_o;     c.vsel = bus.vsel_o;       c.shift = bus.shift_o;
    c.aluop = bus.aluop_o;
    return c;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c = '0;
    c.w = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] dp_model(input logic [15:0] ir);
    int v;
    v = $signed(ir[7:0]);
    return v[15:0];
  endfunction

  function automatic int first_w(input ctl_t obs[$]);
    for (int i = 0; i < obs.size(); i++) if (obs[i].w) return i;
    return -1;
  endfunction

  // Expected control word per cycle, starting with the cycle after s is sampled.
  task automatic model_trace(input logic [15:0] ir, output ctl_t t[$]);
    ctl_t c;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit movi, movr, mvn, add, cmp, andi;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    movi = (opc == 3'd6) && (op == 2'd2);
    movr = (opc == 3'd6) && (op == 2'd0);
    mvn  = (opc == 3'd5) && (op == 2'd3);
    add  = (opc == 3'd5) && (op == 2'd0);
    cmp  = (opc == 3'd5) && (op == 2'd1);
    andi = (opc == 3'd5) && (op == 2'd2);
    t = {};
    t.push_back(ctl_t'(0));
    if (movi) begin
      c = '0; c.writenum = rn; c.vsel = 1'b1; c.write = 1'b1; t.push_back(c);
    end else if (movr || mvn || add || cmp || andi) begin
      if (add || cmp || andi) begin
        c = '0; c.readnum = rn; c.loada = 1'b1; t.push_back(c);
      end
      c = '0; c.readnum = rm; c.loadb = 1'b1; t.push_back(c);
      c = '0; c.shift = sh;
      c.asel  = movr || mvn;
      c.aluop = movr ? 2'b00 : mvn ? 2'b11 : add ? 2'b00 : cmp ? 2'b01 : 2'b10;
      c.loads = cmp;
      c.loadc = !cmp;
      t.push_back(c);
      if (!cmp) begin
        c = '0; c.writenum = rd; c.write = 1'b1; t.push_back(c);
      end
    end
    t.push_back(idle_ctl());
  endtask

  // Starts one instruction from WAIT and records control words until w returns.
  task automatic run_instr(input logic [15:0] ir, input bit do_load, output ctl_t obs[$],
                           output logic [15:0] dp);
    ctl_t cur;
    obs = {};
    @(negedge clk);
    bus.in_i = ir; bus.load_i = do_load; bus.s_i = 1'b1;
    @(negedge clk);
    bus.s_i = 1'b0; bus.load_i = 1'b0;
    dp = bus.datapath_in_o;
    cur = pack_ctl();
    obs.push_back(cur);
    for (int k = 0; k < 12; k++) begin
      if (cur.w) break;
      @(negedge clk);
      cur = pack_ctl();
      obs.push_back(cur);
    end
  endtask

  task automatic test_reset();
    ctl_t cur;
    #12;
    cur = pack_ctl();
    n_checks++;
    if (cur !== idle_ctl()) begin
      n_fail++; $display("FAIL reset_ctl: got %h expected %h", cur, idle_ctl());
    end
    n_checks++;
    if (bus.datapath_in_o !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dp: got %h expected 0000", bus.datapath_in_o);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    cur = pack_ctl();
    n_checks++;
    if (cur !== idle_ctl()) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", cur, idle_ctl());
    end
  endtask

  task automatic test_directed();
    ctl_t obs[$], exp[$];
    logic [15:0] dp;
    int lat;
    for (int k = 0; k < 6; k++) begin
      run_instr(D_IR[k], 1'b1, obs, dp);
      model_trace(D_IR[k], exp);
      lat = first_w(obs);
      n_checks++;
      if (lat != D_LAT[k]) begin
        n_fail++; $display("FAIL latency ir=%h: got %0d expected %0d", D_IR[k], lat, D_LAT[k]);
      end
      n_checks++;
      if (dp !== D_DP[k]) begin
        n_fail++; $display("FAIL datapath_in ir=%h: got %h expected %h", D_IR[k], dp, D_DP[k]);
      end
      n_checks++;
      if (obs.size() != exp.size()) begin
        n_fail++; $display("FAIL trace_len ir=%h: got %0d expected %0d", D_IR[k], obs.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_checks++;
          if (obs[i] !== exp[i]) begin
            n_fail++; $display("FAIL trace ir=%h cycle %0d: got %h expected %h", D_IR[k], i, obs[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_load_busy();
    ctl_t obs[$], exp[$], cur;
    logic [15:0] ir, dp;
    ir = 16'hB36D;
    model_trace(ir, exp);
    obs = {};
    @(negedge clk);
    bus.in_i = ir; bus.load_i = 1'b1; bus.s_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus.s_i = 1'b0;
      cur = pack_ctl();
      obs.push_back(cur);
      if (cur.w) break;
      bus.in_i = 16'($urandom);
    end
    bus.load_i = 1'b0;
    n_checks++;
    if (obs.size() != exp.size()) begin
      n_fail++; $display("FAIL busy_len: got %0d expected %0d", obs.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (obs[i] !== exp[i]) begin
          n_fail++; $display("FAIL busy_trace cycle %0d: got %h expected %h", i, obs[i], exp[i]);
        end
      end
    end
    run_instr(16'h0000, 1'b0, obs, dp);
    n_checks++;
    if (dp !== dp_model(ir)) begin
      n_fail++; $display("FAIL busy_ir_kept dp: got %h expected %h", dp, dp_model(ir));
    end
    n_checks++;
    if (obs.size() != exp.size()) begin
      n_fail++; $display("FAIL rerun_len: got %0d expected %0d", obs.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (obs[i] !== exp[i]) begin
          n_fail++; $display("FAIL rerun_trace cycle %0d: got %h expected %h", i, obs[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ctl_t exp[$], cur, want;
    logic [15:0] ir;
    int L;
    for (int j = 0; j < 2; j++) begin
      ir = (j == 0) ? 16'hD107 : 16'hA0A8;
      model_trace(ir, exp);
      L = exp.size();
      @(negedge clk);
      bus.in_i = ir; bus.load_i = 1'b1; bus.s_i = 1'b1;
      for (int i = 0; i <= 2 * L; i++) begin
        @(negedge clk);
        if (i == 0) bus.load_i = 1'b0;
        if (i == L) bus.s_i = 1'b0;
        cur = pack_ctl();
        want = (i < 2 * L) ? exp[i % L] : exp[L - 1];
        n_checks++;
        if (cur !== want) begin
          n_fail++; $display("FAIL back_to_back ir=%h cycle %0d: got %h expected %h", ir, i, cur, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ctl_t obs[$], exp[$];
    logic [15:0] dp;
    @(negedge clk);
    bus.in_i = 16'hA0A8; bus.load_i = 1'b1; bus.s_i = 1'b1;
    @(negedge clk);
    bus.s_i = 1'b0; bus.load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.loadb_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_getb_loadb: got %b expected 1", bus.loadb_o);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.w_o, bus.write_o, bus.loadb_o, bus.readnum_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL mid_reset w/write/loadb/readnum: got %b%b%b %0d expected 1000",
                         bus.w_o, bus.write_o, bus.loadb_o, bus.readnum_o);
    end
    @(negedge clk);
    reset = 1'b0;
    run_instr(16'hFFFF, 1'b0, obs, dp);
    model_trace(16'h0000, exp);
    n_checks++;
    if (dp !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset_ir dp: got %h expected 0000", dp);
    end
    n_checks++;
    if (obs.size() != exp.size()) begin
      n_fail++; $display("FAIL mid_reset_len: got %0d expected %0d", obs.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (obs[i] !== exp[i]) begin
          n_fail++; $display("FAIL mid_reset_trace cycle %0d: got %h expected %h", i, obs[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    ctl_t obs[$], exp[$];
    logic [15:0] ir, dp;
    int kind;
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: ir[15:11] = 5'b11010;
        1: ir[15:11] = 5'b11000;
        2: ir[15:11] = 5'b10111;
        3: begin ir[15:13] = 3'b101; ir[12:11] = 2'($urandom_range(0, 2)); end
        default: ;
      endcase
      run_instr(ir, 1'b1, obs, dp);
      model_trace(ir, exp);
      n_checks++;
      if (dp !== dp_model(ir)) begin
        n_fail++; $display("FAIL rand_dp ir=%h: got %h expected %h", ir, dp, dp_model(ir));
      end
      n_checks++;
      if (obs.size() != exp.size()) begin
        n_fail++; $display("FAIL rand_len ir=%h: got %0d expected %0d", ir, obs.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_checks++;
          if (obs[i] !== exp[i]) begin
            n_fail++; $display("FAIL rand_trace ir=%h cycle %0d: got %h expected %h", ir, i, obs[i], exp[i]);
          end
          n_checks++;
          if ($countones({obs[i].loada, obs[i].loadb, obs[i].loadc, obs[i].write}) > 1) begin
            n_fail++; $display("FAIL rand_exclusive ir=%h cycle %0d: got %h expected at most one enable",
                               ir, i, obs[i]);
          end
        end
      end
    end
  endtask

  initial begin
    bus.s_i = 1'b0; bus.load_i = 1'b0; bus.in_i = '0;
    test_reset();
    test_directed();
    test_load_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
